// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Grants ownership of the shared Addr_bus/Data_bus to either the CPU (host
// master) or the DMA engine for one whole burst of 1, 2 or 4 beats. Between
// owners the bus sits idle for TURN_CYCLES cycles, and a watchdog aborts a
// burst whose owner stops transferring for HOLD_MAX granted cycles.
//
// Configuration macro:
//   ARB_RR_EN  defined   : a simultaneous CPU/DMA request goes to the master
//                          that was not granted last (last-owner flag resets
//                          to CPU, so the first tie goes to DMA).
//              undefined : DMA always wins a tie; no last-owner flag.
//
// Parameters:
//   TURN_CYCLES  idle cycles with no grant between bursts (1..3)
//   HOLD_MAX     granted cycles without a beat before abort (2..255)
//
// Ports:
//   clck        in   system clock, rising edge
//   Reset       in   synchronous active-high reset
//   cpu_req     in   CPU bus request, held for the whole burst
//   cpu_brust   in   CPU burst code (0=1, 1=2, 2=4 beats, 3=reserved)
//   cpu_beat    in   CPU transfers one word this cycle
//   dma_req     in   DMA bus request
//   dma_brust   in   DMA burst code, same encoding
//   dma_beat    in   DMA transfers one word this cycle
//   cpu_gnt     out  CPU owns the bus
//   dma_gnt     out  DMA owns the bus
//   beat_cnt    out  beats completed in the current burst
//   last_beat   out  current qualified beat completes the burst (comb.)
//   abort       out  one-cycle pulse, burst terminated early
//   brust_err   out  sticky, reserved burst code 3 was latched
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_MAX    = 16
) (
    input  logic       clck,
    input  logic       Reset,
    input  logic       cpu_req,
    input  logic [1:0] cpu_brust,
    input  logic       cpu_beat,
    input  logic       dma_req,
    input  logic [1:0] dma_brust,
    input  logic       dma_beat,
    output logic       cpu_gnt,
    output logic       dma_gnt,
    output logic [2:0] beat_cnt,
    output logic       last_beat,
    output logic       abort,
    output logic       brust_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GNT_CPU = 2'd1;
    localparam logic [1:0] GNT_DMA = 2'd2;
    localparam logic [1:0] TURN    = 2'd3;

    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);

    logic [1:0] state;
    logic [1:0] turn_cnt;
    logic [7:0] wdog;
    logic [2:0] burst_len;

`ifdef ARB_RR_EN
    // 1 when the DMA engine was the most recent owner, 0 for the CPU.
    logic last_dma;
`endif

    logic       own_req;
    logic       own_beat;
    logic       pick_dma;
    logic       pick_cpu;
    logic [1:0] win_brust;

    // Burst code to beat count; the reserved code falls back to one beat.
    function automatic logic [2:0] brust_len(input logic [1:0] code);
        case (code)
            2'd1:    brust_len = 3'd2;
            2'd2:    brust_len = 3'd4;
            default: brust_len = 3'd1;
        endcase
    endfunction

    // Grants are a decode of the registered state, so they change only on
    // the clock edge and can never both be high.
    assign cpu_gnt = (state == GNT_CPU);
    assign dma_gnt = (state == GNT_DMA);

    // NOTE: every signal assigned in an always_comb gets a default at the
    // top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        own_req  = 1'b0;
        own_beat = 1'b0;
        case (state)
            GNT_CPU: begin
                own_req  = cpu_req;
                own_beat = cpu_beat;
            end
            GNT_DMA: begin
                own_req  = dma_req;
                own_beat = dma_beat;
            end
            default: ;
        endcase
    end

    // Tie resolution between the two masters while IDLE.
`ifdef ARB_RR_EN
    assign pick_dma = dma_req & (~cpu_req | ~last_dma);
`else
    assign pick_dma = dma_req;
`endif
    assign pick_cpu  = cpu_req & ~pick_dma;
    assign win_brust = pick_dma ? dma_brust : cpu_brust;

    // own_beat is only ever set in a grant state, so it already carries the
    // grant qualification.
    assign last_beat = own_beat & (beat_cnt == burst_len - 3'd1);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clck) begin
        if (Reset) begin
            state     <= IDLE;
            turn_cnt  <= 2'd0;
            wdog      <= 8'd0;
            burst_len <= 3'd1;
            beat_cnt  <= 3'd0;
            abort     <= 1'b0;
            brust_err <= 1'b0;
`ifdef ARB_RR_EN
            last_dma  <= 1'b0;
`endif
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_dma || pick_cpu) begin
                        state     <= pick_dma ? GNT_DMA : GNT_CPU;
                        burst_len <= brust_len(win_brust);
                        beat_cnt  <= 3'd0;
                        wdog      <= 8'd0;
                        if (win_brust == 2'd3) begin
                            brust_err <= 1'b1;
                        end
`ifdef ARB_RR_EN
                        // Recorded at grant time so an aborted burst still
                        // counts as that master's turn.
                        last_dma  <= pick_dma;
`endif
                    end
                end

                GNT_CPU, GNT_DMA: begin
                    if (last_beat) begin
                        // Completion takes precedence over a simultaneous
                        // request drop.
                        state    <= TURN;
                        turn_cnt <= 2'd0;
                        beat_cnt <= 3'd0;
                        wdog     <= 8'd0;
                    end else if (!own_req) begin
                        state    <= TURN;
                        turn_cnt <= 2'd0;
                        beat_cnt <= 3'd0;
                        wdog     <= 8'd0;
                        abort    <= 1'b1;
                    end else if (own_beat) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        wdog     <= 8'd0;
                    end else if (wdog == HOLD_LAST) begin
                        // This idle cycle brings the watchdog to HOLD_MAX.
                        state    <= TURN;
                        turn_cnt <= 2'd0;
                        beat_cnt <= 3'd0;
                        wdog     <= HOLD_SAT;
                        abort    <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end

                default: begin
                    // TURN: requests are ignored until the gap has elapsed.
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter with TURN_CYCLES=1 and HOLD_MAX=16. A table
// of per-cycle records (inputs plus the outputs expected during that same
// cycle) covers the burst, gap, abort and reset cases; hand-written
// sequences cover the watchdog and the simultaneous-request ties. Inputs
// change on the falling edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clck = 1'b0;
    logic       Reset;
    logic       cpu_req;
    logic [1:0] cpu_brust;
    logic       cpu_beat;
    logic       dma_req;
    logic [1:0] dma_brust;
    logic       dma_beat;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic [2:0] beat_cnt;
    logic       last_beat;
    logic       abort;
    logic       brust_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       creq;
        logic [1:0] cbr;
        logic       cbt;
        logic       dreq;
        logic [1:0] dbr;
        logic       dbt;
        logic       e_cg;
        logic       e_dg;
        logic [2:0] e_bc;
        logic       e_lb;
        logic       e_ab;
        logic       e_be;
    } vec_t;

    vec_t vq[$];

    bus_arbiter #(
        .TURN_CYCLES(1),
        .HOLD_MAX   (16)
    ) dut (
        .clck     (clck),
        .Reset    (Reset),
        .cpu_req  (cpu_req),
        .cpu_brust(cpu_brust),
        .cpu_beat (cpu_beat),
        .dma_req  (dma_req),
        .dma_brust(dma_brust),
        .dma_beat (dma_beat),
        .cpu_gnt  (cpu_gnt),
        .dma_gnt  (dma_gnt),
        .beat_cnt (beat_cnt),
        .last_beat(last_beat),
        .abort    (abort),
        .brust_err(brust_err)
    );

    always #5 clck = ~clck;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic creq, input logic [1:0] cbr,
                         input logic cbt, input logic dreq, input logic [1:0] dbr,
                         input logic dbt);
        Reset     = rst;
        cpu_req   = creq;
        cpu_brust = cbr;
        cpu_beat  = cbt;
        dma_req   = dreq;
        dma_brust = dbr;
        dma_beat  = dbt;
    endtask

    function automatic vec_t mk(input logic rst, input logic creq, input logic [1:0] cbr,
                                input logic cbt, input logic dreq, input logic [1:0] dbr,
                                input logic dbt, input logic cg, input logic dg,
                                input logic [2:0] bc, input logic lb, input logic ab,
                                input logic be);
        vec_t v;
        v.rst  = rst;  v.creq = creq; v.cbr = cbr; v.cbt = cbt;
        v.dreq = dreq; v.dbr  = dbr;  v.dbt = dbt;
        v.e_cg = cg;   v.e_dg = dg;   v.e_bc = bc; v.e_lb = lb;
        v.e_ab = ab;   v.e_be = be;
        return v;
    endfunction

    initial begin
        //           rst creq cbr cbt dreq dbr dbt | cg dg bc lb ab be
        // 4-beat DMA burst, one beat per cycle, then the turnaround gap.
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 0, 0, 0, 0, 0)); // 0 idle, reset state
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 1, 0, 0, 0, 0)); // 1
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 1, 1, 0, 0, 0)); // 2
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 1, 2, 0, 0, 0)); // 3
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 1, 3, 1, 0, 0)); // 4 last beat
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 5 turn
        // 2-beat CPU burst with beats on grant cycles 2 and 5.
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 6 idle
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // 7
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // 8 beat 1
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0)); // 9 gap
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0)); // 10 gap
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0)); // 11 beat 2
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 12 turn
        // DMA 4-beat request dropped after 2 beats, CPU waiting.
        vq.push_back(mk(0, 1, 0, 0, 1, 2, 0,  0, 0, 0, 0, 0, 0)); // 13 tie -> DMA
        vq.push_back(mk(0, 1, 0, 0, 1, 2, 1,  0, 1, 0, 0, 0, 0)); // 14
        vq.push_back(mk(0, 1, 0, 0, 1, 2, 1,  0, 1, 1, 0, 0, 0)); // 15
        vq.push_back(mk(0, 1, 0, 0, 0, 2, 0,  0, 1, 2, 0, 0, 0)); // 16 req drop
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0)); // 17 abort, turn
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 18 idle
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0)); // 19 CPU 1-beat
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 20 turn
        // Reset mid 4-beat DMA burst, then a reserved-code CPU request.
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 0, 0, 0, 0, 0)); // 21 idle
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 1, 0, 0, 0, 0)); // 22
        vq.push_back(mk(0, 0, 0, 0, 1, 2, 1,  0, 1, 1, 0, 0, 0)); // 23
        vq.push_back(mk(1, 0, 0, 0, 1, 2, 1,  0, 1, 2, 0, 0, 0)); // 24 reset here
        vq.push_back(mk(0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 25 idle after reset
        vq.push_back(mk(0, 1, 3, 1, 0, 0, 0,  1, 0, 0, 1, 0, 1)); // 26 1-beat, err
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1)); // 27 err sticky

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clck);
        @(negedge clck);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].creq, vq[i].cbr, vq[i].cbt,
                  vq[i].dreq, vq[i].dbr, vq[i].dbt);
            #1;
            check($sformatf("row%0d cpu_gnt", i),   8'(cpu_gnt),   8'(vq[i].e_cg));
            check($sformatf("row%0d dma_gnt", i),   8'(dma_gnt),   8'(vq[i].e_dg));
            check($sformatf("row%0d beat_cnt", i),  8'(beat_cnt),  8'(vq[i].e_bc));
            check($sformatf("row%0d last_beat", i), 8'(last_beat), 8'(vq[i].e_lb));
            check($sformatf("row%0d abort", i),     8'(abort),     8'(vq[i].e_ab));
            check($sformatf("row%0d brust_err", i), 8'(brust_err), 8'(vq[i].e_be));
            @(negedge clck);
        end

        // Watchdog: CPU holds a 1-beat grant without ever transferring.
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("wd idle cpu_gnt", 8'(cpu_gnt), 8'd0);
        @(negedge clck);
        for (int c = 1; c <= 16; c++) begin
            #1;
            check($sformatf("wd cyc%0d cpu_gnt", c), 8'(cpu_gnt), 8'd1);
            check($sformatf("wd cyc%0d abort", c),   8'(abort),   8'd0);
            @(negedge clck);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wd after cpu_gnt", 8'(cpu_gnt), 8'd0);
        check("wd after abort",   8'(abort),   8'd1);
        @(negedge clck);

        // Two back-to-back simultaneous 1-beat requests; both beat inputs are
        // high so whichever master owns the bus completes in one cycle.
        drive(0, 1, 0, 1, 1, 0, 1);
        #1;
        check("tie idle abort",   8'(abort),   8'd0);
        check("tie idle cpu_gnt", 8'(cpu_gnt), 8'd0);
        check("tie idle dma_gnt", 8'(dma_gnt), 8'd0);
        @(negedge clck);
        #1;
        check("tie1 dma_gnt",   8'(dma_gnt),   8'd1);
        check("tie1 cpu_gnt",   8'(cpu_gnt),   8'd0);
        check("tie1 last_beat", 8'(last_beat), 8'd1);
        @(negedge clck);
        #1;
        check("tie1 turn dma_gnt", 8'(dma_gnt), 8'd0);
        check("tie1 turn cpu_gnt", 8'(cpu_gnt), 8'd0);
        @(negedge clck);
        #1;
        check("tie2 idle dma_gnt", 8'(dma_gnt), 8'd0);
        check("tie2 idle cpu_gnt", 8'(cpu_gnt), 8'd0);
        @(negedge clck);
        #1;
`ifdef ARB_RR_EN
        check("tie2 dma_gnt", 8'(dma_gnt), 8'd0);
        check("tie2 cpu_gnt", 8'(cpu_gnt), 8'd1);
`else
        check("tie2 dma_gnt", 8'(dma_gnt), 8'd1);
        check("tie2 cpu_gnt", 8'(cpu_gnt), 8'd0);
`endif
        check("tie2 last_beat", 8'(last_beat), 8'd1);
        @(negedge clck);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("tie2 turn dma_gnt", 8'(dma_gnt), 8'd0);
        check("tie2 turn cpu_gnt", 8'(cpu_gnt), 8'd0);
        check("tie2 turn abort",   8'(abort),   8'd0);
        @(negedge clck);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates the shared Addr_bus/Data_bus between the CPU (host master) and the DMA engine (bus master).
- Grants ownership for one whole burst: 1, 2 or 4 beats, selected by the requester's 2-bit brust code.
- Inserts a turnaround gap between owners and aborts stalled bursts with a watchdog.
- Sits between CPU/DMA and the IO_1/IO_2/memory slaves; generates the bus ownership the other blocks rely on.

Parameters:
- TURN_CYCLES, 1, idle cycles with no grant between releasing and re-granting the bus (1..3).
- HOLD_MAX, 16, consecutive granted cycles without a beat before the watchdog aborts (2..255).

Ports:
- clck  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU requests the bus; held for the whole burst.
- cpu_brust  in  2  CPU burst code: 0=1 beat, 1=2 beats, 2=4 beats, 3=reserved.
- cpu_beat  in  1  CPU transfers one word this cycle (qualified by cpu_gnt).
- dma_req  in  1  DMA requests the bus (Breq).
- dma_brust  in  2  DMA burst code, same encoding.
- dma_beat  in  1  DMA transfers one word this cycle (qualified by dma_gnt).
- cpu_gnt  out  1  CPU owns the bus.
- dma_gnt  out  1  DMA owns the bus (Back).
- beat_cnt  out  3  beats completed in the current burst.
- last_beat  out  1  combinational: the current qualified beat completes the burst.
- abort  out  1  one-cycle pulse: burst terminated early.
- brust_err  out  1  sticky: reserved code 3 was latched; cleared only by Reset.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next clck edge, including mid-burst. Reset values:
  - cpu_gnt=0, dma_gnt=0, beat_cnt=0, abort=0, brust_err=0.
  - State=IDLE, turnaround counter=0, watchdog=0, latched length=1.
- States: IDLE, GNT_CPU, GNT_DMA, TURN.
- IDLE:
  - Samples the requests at the rising edge.
  - Grant is registered and asserts the cycle after the request is first seen (1-cycle latency).
  - dma_req only -> GNT_DMA. cpu_req only -> GNT_CPU.
  - Both asserted -> GNT_DMA: DMA has fixed priority in the default build.
  - On entry to a grant state, the winner's brust code is latched as length L (0->1, 1->2, 2->4).
  - Code 3 latches L=1 and sets brust_err.
- GNT_x:
  - Exactly one grant is high; both grants are never high in the same cycle.
  - beat_cnt increments on each x_beat. Beats from the non-owner are ignored.
  - last_beat = gnt_x & x_beat & (beat_cnt == L-1).
  - On last_beat: beat_cnt clears and the state goes to TURN; the grant drops at the next edge.
  - x_req deasserted before last_beat: abort pulses for 1 cycle, grant drops, -> TURN.
  - The watchdog counts granted cycles without a beat and resets on every beat.
  - Watchdog reaching HOLD_MAX: abort pulses, -> TURN.
  - A beat and a request drop in the same cycle: the beat counts; last_beat wins over abort if both apply.
- TURN:
  - Both grants are 0 for TURN_CYCLES cycles, then IDLE.
  - Requests are ignored while in TURN.
  - Earliest re-grant is therefore TURN_CYCLES+1 cycles after the grant drops.
- Widths:
  - beat_cnt is 3 bits and never exceeds 3.
  - The watchdog is 8 bits and saturates at HOLD_MAX.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: on simultaneous cpu_req and dma_req in IDLE, the grant goes to the master NOT granted last, tracked by a last-owner flag.
  - The last-owner flag resets to CPU, so the first tie goes to DMA.
  - An aborted burst still counts as that master's turn.
- Undefined: fixed DMA priority, and the last-owner flag is not implemented.

Test Plan:
- Reset, then dma_req=1, dma_brust=2, dma_beat=1 each cycle -> dma_gnt high 1 cycle later for exactly 4 cycles; beat_cnt 0,1,2,3; last_beat on the 4th beat; next 1 cycle has both grants 0.
- cpu_req=1, cpu_brust=1, with cpu_beat only on cycles 2 and 5 of the grant -> cpu_gnt held until the 2nd beat; beat_cnt stays 1 during the gap; no abort.
- cpu_req and dma_req rise together for two consecutive bursts (brust=0):
  - Default build -> DMA, then DMA again.
  - With ARB_RR_EN -> DMA, then CPU.
- dma_req=1, brust=2, dma_req dropped after 2 beats -> abort pulse for 1 cycle, dma_gnt drops, beat_cnt=0, cpu_req pending is granted after TURN.
- cpu_req held, brust=0, cpu_beat never asserted with HOLD_MAX=16 -> abort on the 16th granted cycle, cpu_gnt=0 next cycle.
- Reset asserted mid 4-beat DMA burst (beat_cnt=2) -> next edge: all outputs 0, state IDLE; cpu_brust=3 request afterwards -> brust_err=1, 1-beat grant.
